// File: rtl/ptr_sync_rd.sv
`default_nettype none
// ============================================================================
// Module      : ptr_sync_rd
// Description : Read-domain receiver for the async FIFO write pointer.
//               The Gray write pointer passes through a SYNC_STAGES-deep
//               plain-register synchroniser. A registered stage then converts
//               it to binary. That binary value is combined with the local
//               read pointer to give the fill level and the empty flag.
//               A warm-up qualifier masks the chain flush after reset.
//               Sticky debug checks flag illegal pointer steps and level
//               overflow.
// Ports       : RCLK        read-domain clock
//               RRSTn       asynchronous active-low reset
//               wpt         Gray write pointer (write-clock domain)
//               rbin        binary read pointer (RCLK domain)
//               err_clr     synchronous clear of step_err / lvl_err
//               wgray_sync  last synchroniser stage
//               wbin_sync   registered binary of wgray_sync
//               rd_level    wbin_sync - rbin (modulo pointer width)
//               rd_empty    level is zero or sync not yet valid
//               sync_valid  chain has flushed since reset
//               step_err    sticky illegal pointer advance
//               lvl_err     sticky level above DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module ptr_sync_rd #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_STEP    = 16
) (
    input  logic                  RCLK,
    input  logic                  RRSTn,
    input  logic [ADDR_WIDTH:0]   wpt,
    input  logic [ADDR_WIDTH:0]   rbin,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH:0]   wgray_sync,
    output logic [ADDR_WIDTH:0]   wbin_sync,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  rd_empty,
    output logic                  sync_valid,
    output logic                  step_err,
    output logic                  lvl_err
);

    localparam int                   C_PW       = ADDR_WIDTH + 1;
    localparam int                   C_DEPTH    = 1 << ADDR_WIDTH;
    localparam int                   C_CNT_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [C_CNT_W-1:0]   C_CNT_MAX  = C_CNT_W'(SYNC_STAGES + 1);
    localparam logic [C_PW-1:0]      C_MAX_STEP = C_PW'(MAX_STEP);
    localparam logic [C_PW-1:0]      C_DEPTH_V  = C_PW'(C_DEPTH);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("ptr_sync_rd: SYNC_STAGES must be in 2..4");
    end
    if (MAX_STEP < 1 || MAX_STEP > C_DEPTH) begin : g_bad_max_step
        $error("ptr_sync_rd: MAX_STEP must be in 1..DEPTH");
    end

    function automatic logic [C_PW-1:0] gray2bin(input logic [C_PW-1:0] g);
        logic [C_PW-1:0] b;
        b[C_PW-1] = g[C_PW-1];
        for (int i = C_PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser chain: pure register-to-register, no logic in between
    // ------------------------------------------------------------------
    logic [C_PW-1:0] sync_d [SYNC_STAGES];
    logic [C_PW-1:0] sync_q [SYNC_STAGES];

    always_comb begin
        sync_d[0] = wpt;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_ff @(posedge RCLK or negedge RRSTn) begin
        if (!RRSTn) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign wgray_sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [C_PW-1:0]    wbin_sync_d, wbin_sync_q;
    logic [C_CNT_W-1:0] cnt_d, cnt_q;
    logic               sync_valid_d, sync_valid_q;
    logic [C_PW-1:0]    prev_d, prev_q;
    logic               prev_vld_d, prev_vld_q;
    logic               step_hit_d, step_hit_q;
    logic               step_err_d, step_err_q;
    logic               lvl_err_d, lvl_err_q;
    logic [C_PW-1:0]    step_delta;
    logic               lvl_hit;

    always_comb begin
        wbin_sync_d  = gray2bin(wgray_sync);

        // Warm-up counter saturates once the chain plus the binary stage
        // hold post-reset samples.
        cnt_d        = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        sync_valid_d = sync_valid_q | (cnt_d == C_CNT_MAX);

        // The first valid edge only primes prev; later edges compare the
        // new sample against it. A violation is registered in step_hit
        // and becomes sticky in step_err one edge later.
        step_delta   = wbin_sync_q - prev_q;
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
        step_hit_d   = 1'b0;
        if (sync_valid_q) begin
            prev_d     = wbin_sync_q;
            prev_vld_d = 1'b1;
            step_hit_d = prev_vld_q && (step_delta > C_MAX_STEP);
        end

        lvl_hit      = sync_valid_q && (rd_level > C_DEPTH_V);

        // Clear has lower priority than a fresh violation.
        step_err_d   = (step_err_q & ~err_clr) | step_hit_q;
        lvl_err_d    = (lvl_err_q  & ~err_clr) | lvl_hit;
    end

    always_ff @(posedge RCLK or negedge RRSTn) begin
        if (!RRSTn) begin
            wbin_sync_q  <= '0;
            cnt_q        <= '0;
            sync_valid_q <= 1'b0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            step_hit_q   <= 1'b0;
            step_err_q   <= 1'b0;
            lvl_err_q    <= 1'b0;
        end else begin
            wbin_sync_q  <= wbin_sync_d;
            cnt_q        <= cnt_d;
            sync_valid_q <= sync_valid_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            step_hit_q   <= step_hit_d;
            step_err_q   <= step_err_d;
            lvl_err_q    <= lvl_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wbin_sync  = wbin_sync_q;
    assign sync_valid = sync_valid_q;
    assign step_err   = step_err_q;
    assign lvl_err    = lvl_err_q;
    // Modulo subtraction handles pointer wrap through the extra MSB.
    assign rd_level   = wbin_sync_q - rbin;
    // Until the chain has flushed, report empty so stale data is never read.
    assign rd_empty   = (rd_level == '0) | ~sync_valid_q;

endmodule
`default_nettype wire
